mult25_splitter: RTL and testbench
==================================

Name: mult25_splitter

Overview:
- Takes a 13-bit accumulated total and decomposes it into a stream of 4-bit operands X (0..15), such that the sum of 25*X over all beats plus a final remainder equals the total.
- It is the inverse of the multiples-of-25 accumulator datapath and sits downstream of it.
- Input and output each use a valid/ready handshake.
- Beats are produced greedily: the largest X the current residual allows, one beat per transfer.

Parameters:
- IN_W, 13, width of input total.
- X_W, 4, width of emitted operand. X_MAX = 2^X_W - 1.
- MULT, 25, constant multiplier. Must satisfy MULT < 32, so the remainder fits REM_W.
- REM_W, 5, remainder width. Must satisfy 2^REM_W > MULT - 1.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- in_valid  input  1  in_value is offered.
- in_ready  output  1  block can accept a new total.
- in_value  input  IN_W  total to decompose.
- out_valid  output  1  beat is presented.
- out_ready  input  1  downstream accepts the beat.
- out_x  output  X_W  operand for this beat.
- out_last  output  1  final beat of the current total.
- out_rem  output  REM_W  remainder. Meaningful only when out_last=1, else 0.
- out_beat  output  5  index of the current beat, 0-based.

Behaviour:
- Reset, sampled at a rising edge with reset=0:
  - state=IDLE, residual=0.
  - out_valid=0, out_x=0, out_last=0, out_rem=0, out_beat=0.
  - in_ready=1 from the first edge with reset low.
  - in_valid is ignored while reset=0.
- States: IDLE, EMIT.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: residual<=in_value, state<=EMIT, and the first beat is registered.
  - out_valid rises the cycle after acceptance (latency 1).
- Beat formation:
  - x = largest k in 0..X_MAX with MULT*k <= residual, from a constant-comparator selector.
  - nxt = residual - MULT*x.
  - last = (nxt < MULT).
  - rem = last ? nxt[REM_W-1:0] : 0.
  - All outputs are registered.
- EMIT:
  - in_ready=0.
  - Outputs are held stable while out_valid&&!out_ready.
  - On transfer (out_valid&&out_ready) with out_last=0: residual<=nxt, out_beat++, next beat registered the same edge. Beats are back-to-back, with no bubble.
  - On transfer with out_last=1: out_valid<=0, state<=IDLE, out_beat<=0.
  - in_ready rises the cycle after the last transfer. There is no same-cycle overlap of last beat and new acceptance.
- Arithmetic:
  - MULT*k is computed at IN_W bits, with no overflow for k<=15.
  - Beat count = ceil(floor(in_value/MULT)/15), minimum 1.
  - Max beats for 8191 is 22, so out_beat fits 5 bits.
- Boundary cases:
  - in_value < MULT, including 0: a single beat with x=0, last=1, rem=in_value.
  - residual exactly 15*MULT: x=15, last=1, rem=0.
  - residual 16*MULT: beat x=15 with last=0, then beat x=1 with last=1.
- Reset mid-stream:
  - The stream is abandoned and no last beat is emitted.
  - All outputs return to reset values at the next edge.
- in_valid while busy is not accepted, because in_ready=0. The upstream must hold the value.

Decomposition:
- Package mult25_pkg holds:
  - constants MULT, X_MAX, REM_W;
  - state enum {IDLE, EMIT};
  - function max_mult_le(residual), returning x.
- One sub-module: mult25_quot_sel, the combinational largest-k selector. Inputs: residual. Outputs: x and nxt.

Test Plan:
- Reset low 2 cycles, then high, then offer 250 -> in_ready=1 after reset; one beat: x=10, last=1, rem=0, beat=0, 1 cycle after acceptance.
- 1000 with out_ready=1 -> beats x=15, 15, 10 on consecutive cycles; last only on the third; rem=0; in_ready=1 the cycle after.
- 8191 -> 21 beats of x=15, then x=12 with last=1 and rem=16; out_beat runs 0..21.
- Offer 24, then 0, then 400 -> {x=0, last, rem=24}; {x=0, last, rem=0}; {x=15, last=0}, then {x=1, last, rem=0}.
- 1000 with out_ready toggled pseudo-randomly -> out_x/out_last/out_beat stable during stalls; same beat sequence as the unstalled run; in_ready=0 throughout.
- 8191, reset=0 asserted at beat 5 -> out_valid=0, in_ready=1 next edge, no last seen; next offer of 250 gives the normal single beat.

Source files
------------

// File: rtl/mult25_pkg.sv
// -----------------------------------------------------------------------------
// mult25_pkg
// Shared constants, state type and the quotient helper for the multiples-of-25
// splitter. A 13-bit total is broken into 4-bit operands X so that
// sum(25*X) + remainder == total.
//
// Contents:
//   IN_W, X_W, X_MAX, MULT, REM_W, BEAT_W : datapath widths and constants
//   state_t                               : splitter FSM states {IDLE, EMIT}
//   max_mult_le(residual)                 : largest k <= X_MAX with MULT*k <= residual
// -----------------------------------------------------------------------------
package mult25_pkg;

    localparam int IN_W   = 13;
    localparam int X_W    = 4;
    localparam int X_MAX  = (1 << X_W) - 1;
    localparam int MULT   = 25;
    localparam int REM_W  = 5;
    // Worst case 8191 -> 22 beats, indices 0..21.
    localparam int BEAT_W = 5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Bank of constant comparators: each MULT*k is a compile-time constant, so
    // this unrolls into X_MAX parallel compares followed by a priority pick.
    // MULT*X_MAX = 375 fits comfortably in IN_W bits, so no product overflows.
    function automatic logic [X_W-1:0] max_mult_le(input logic [IN_W-1:0] residual);
        logic [X_W-1:0] x;
        x = '0;
        for (int k = 1; k <= X_MAX; k++) begin
            if (IN_W'(MULT * k) <= residual) begin
                x = X_W'(k);
            end
        end
        return x;
    endfunction

endpackage

// File: rtl/mult25_quot_sel.sv
// -----------------------------------------------------------------------------
// mult25_quot_sel
// Combinational greedy selector: picks the largest operand x whose multiple of
// MULT still fits the residual, and returns what is left over after that beat.
//
// Ports:
//   residual : in  IN_W  amount still to be decomposed
//   x        : out X_W   operand for this beat (0..X_MAX)
//   nxt      : out IN_W  residual - MULT*x
// -----------------------------------------------------------------------------
module mult25_quot_sel
    import mult25_pkg::*;
(
    input  logic [IN_W-1:0] residual,
    output logic [X_W-1:0]  x,
    output logic [IN_W-1:0] nxt
);

    assign x   = max_mult_le(residual);
    // x was chosen so that MULT*x <= residual; the subtraction never wraps.
    assign nxt = residual - (IN_W'(MULT) * IN_W'(x));

endmodule

// File: rtl/mult25_splitter.sv
// -----------------------------------------------------------------------------
// mult25_splitter
// Inverse of the multiples-of-25 accumulator. Accepts a 13-bit total over a
// valid/ready input and emits a stream of beats over a valid/ready output.
// Each beat carries the largest operand the remaining amount allows; the final
// beat is flagged with out_last and carries the sub-MULT remainder.
//
// Ports:
//   clk       : in   rising-edge clock
//   reset     : in   synchronous active-low reset
//   in_valid  : in   in_value is offered
//   in_ready  : out  block can accept a new total (only while idle)
//   in_value  : in   IN_W total to decompose
//   out_valid : out  a beat is presented
//   out_ready : in   downstream accepts the beat
//   out_x     : out  X_W operand for this beat
//   out_last  : out  final beat of the current total
//   out_rem   : out  REM_W remainder, non-zero only on the last beat
//   out_beat  : out  BEAT_W 0-based index of the current beat
// -----------------------------------------------------------------------------
module mult25_splitter
    import mult25_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_value,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [X_W-1:0]    out_x,
    output logic              out_last,
    output logic [REM_W-1:0]  out_rem,
    output logic [BEAT_W-1:0] out_beat
);

    state_t            state;
    // Holds what remains AFTER the beat currently on the outputs, so the next
    // beat can be formed from it directly on the transfer edge (no bubble).
    logic [IN_W-1:0]   residual;

    logic [IN_W-1:0]   sel_in;
    logic [X_W-1:0]    sel_x;
    logic [IN_W-1:0]   sel_nxt;
    logic              sel_last;
    logic [REM_W-1:0]  sel_rem;

    // While idle the selector looks at the incoming total; while emitting it
    // looks ahead at the amount left after the presented beat.
    assign sel_in = (state == IDLE) ? in_value : residual;

    mult25_quot_sel u_quot_sel (
        .residual (sel_in),
        .x        (sel_x),
        .nxt      (sel_nxt)
    );

    // NOTE: every signal written in always_comb gets a default first so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        sel_last = 1'b0;
        sel_rem  = '0;
        if (sel_nxt < IN_W'(MULT)) begin
            sel_last = 1'b1;
            // Below MULT the leftover fits REM_W bits, so the slice is lossless.
            sel_rem  = sel_nxt[REM_W-1:0];
        end
    end

    // Input side is open exactly when no total is in flight; this is what
    // prevents the last beat and a new acceptance sharing a cycle.
    assign in_ready = (state == IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesised flops.
    // NOTE: the reset is synchronous and only clears control and output
    // registers; there are no memories here that would need a reset sweep.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            residual  <= '0;
            out_valid <= 1'b0;
            out_x     <= '0;
            out_last  <= 1'b0;
            out_rem   <= '0;
            out_beat  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // First beat registered on the acceptance edge.
                        state     <= EMIT;
                        residual  <= sel_nxt;
                        out_valid <= 1'b1;
                        out_x     <= sel_x;
                        out_last  <= sel_last;
                        out_rem   <= sel_rem;
                        out_beat  <= '0;
                    end
                end

                EMIT: begin
                    if (out_valid && out_ready) begin
                        if (out_last) begin
                            state     <= IDLE;
                            residual  <= '0;
                            out_valid <= 1'b0;
                            out_x     <= '0;
                            out_last  <= 1'b0;
                            out_rem   <= '0;
                            out_beat  <= '0;
                        end else begin
                            residual  <= sel_nxt;
                            out_x     <= sel_x;
                            out_last  <= sel_last;
                            out_rem   <= sel_rem;
                            out_beat  <= out_beat + BEAT_W'(1);
                        end
                    end
                    // Stalled: all outputs hold their registered values.
                end

                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult25_splitter.sv
// -----------------------------------------------------------------------------
// tb_mult25_splitter
// Self-checking bench. The expected beat list for each accepted total is
// computed from the closed-form decomposition (quotient by 25, chunks of 15,
// remainder) and queued; one compare process checks every cycle's outputs
// against the head of that queue.
// -----------------------------------------------------------------------------
module tb_mult25_splitter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [12:0] in_value = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  out_x;
    logic        out_last;
    logic [4:0]  out_rem;
    logic [4:0]  out_beat;

    mult25_splitter dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_value  (in_value),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_last  (out_last),
        .out_rem   (out_rem),
        .out_beat  (out_beat)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int last;
        int rem;
        int idx;
    } beat_t;

    beat_t exp_q[$];
    int    vectors     = 0;
    int    miscompares = 0;
    int    beats_total = 0;
    logic  rst_sampled = 1'b0;
    logic  started     = 1'b0;
    logic  stall_mode  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Closed form: q = v/25 multiples in total, handed out 15 at a time.
    task automatic model_push(input int v);
        int q;
        int n;
        q = v / 25;
        n = (q + 14) / 15;
        if (n < 1) n = 1;
        for (int i = 0; i < n; i++) begin
            beat_t b;
            b.last = (i == n - 1) ? 1 : 0;
            b.x    = b.last ? (q - 15 * (n - 1)) : 15;
            b.rem  = b.last ? (v - 25 * q) : 0;
            b.idx  = i;
            exp_q.push_back(b);
        end
    endtask

    always @(posedge clk) begin
        rst_sampled <= !reset;
        if (!reset) started <= 1'b1;
    end

    always @(posedge clk) begin
        #1;
        out_ready = stall_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    // Compare process, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_sampled) begin
            check("rst_out_valid", out_valid, 0);
            check("rst_out_x", out_x, 0);
            check("rst_out_last", out_last, 0);
            check("rst_out_rem", out_rem, 0);
            check("rst_out_beat", out_beat, 0);
            check("rst_in_ready", in_ready, 1);
        end
        if (!reset) begin
            exp_q.delete();
        end else if (started) begin
            check("in_ready", in_ready, exp_q.size() == 0);
            check("out_valid", out_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                check("out_x", out_x, exp_q[0].x);
                check("out_last", out_last, exp_q[0].last);
                check("out_rem", out_rem, exp_q[0].rem);
                check("out_beat", out_beat, exp_q[0].idx);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    beats_total++;
                end
            end else if (in_valid) begin
                model_push(int'(in_value));
            end
        end
    end

    task automatic offer(input int v);
        int n;
        @(posedge clk);
        #2;
        in_valid = 1'b1;
        in_value = 13'(v);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 400);
        if (!in_ready) check("offer_timeout", n, 0);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(in_ready && exp_q.size() == 0) && n < 400);
        if (n >= 400) check("idle_timeout", n, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        int n;
        int v;

        // Pin the model against hand-computed decompositions.
        model_push(8191);
        check("model_8191_len", exp_q.size(), 22);
        check("model_8191_first", exp_q[0].x, 15);
        check("model_8191_lastx", exp_q[21].x, 12);
        check("model_8191_rem", exp_q[21].rem, 16);
        exp_q.delete();
        model_push(1000);
        check("model_1000_len", exp_q.size(), 3);
        check("model_1000_lastx", exp_q[2].x, 10);
        exp_q.delete();
        model_push(400);
        check("model_400_len", exp_q.size(), 2);
        check("model_400_lastx", exp_q[1].x, 1);
        exp_q.delete();
        model_push(24);
        check("model_24_rem", exp_q[0].rem, 24);
        exp_q.delete();

        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;

        // Directed cases, unstalled.
        offer(250);  wait_idle();
        offer(1000); wait_idle();
        offer(8191); wait_idle();
        offer(24);   wait_idle();
        offer(0);    wait_idle();
        offer(400);  wait_idle();
        offer(375);  wait_idle();

        // Same total with random backpressure.
        stall_mode = 1'b1;
        offer(1000); wait_idle();
        stall_mode = 1'b0;

        // Reset in the middle of a long stream.
        start = beats_total;
        offer(8191);
        n = 0;
        while (beats_total - start < 5 && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 400) check("midstream_timeout", n, 0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        wait_idle();
        offer(250); wait_idle();

        // Randomised totals, back-to-back offers held while busy.
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0: v = int'($urandom_range(0, 8191));
                1: v = int'($urandom_range(0, 24));
                2: v = 374 + int'($urandom_range(0, 26));
                default: v = 25 * int'($urandom_range(1, 30));
            endcase
            stall_mode = ($urandom_range(0, 1) == 1);
            offer(v);
        end
        wait_idle();
        stall_mode = 1'b0;
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
